param_up_down_counter: RTL

Parametrised up/down counter; the general-purpose successor to the fixed 4-bit counter, for timers, credit counters and address sequencers. Width and reset value are configurable. Count range is bounded by a runtime `limit`, with selectable wrap or saturate behaviour. Adds parallel load, bound flags and registered overflow/underflow pulses. An optional compile-time prescaler divides the step rate.

---
 rtl/param_udc_pkg.sv | 14 +
 rtl/udc_prescaler.sv | 32 +++
 rtl/param_up_down_counter.sv | 94 +++++++++
 3 files changed

// File: rtl/param_udc_pkg.sv
// Shared types and constants for the parameterised up/down counter.
package param_udc_pkg;

    // Behaviour when a step runs past the bound of the count range.
    typedef enum logic {
        UDC_WRAP = 1'b0,
        UDC_SAT  = 1'b1
    } udc_mode_t;

    // Encoding of the up_down input.
    localparam logic UDC_UP   = 1'b1;
    localparam logic UDC_DOWN = 1'b0;

endpackage

// File: rtl/udc_prescaler.sv
// Step-rate divider for the up/down counter. Produces one tick every
// PRESCALE enabled cycles. Only instantiated when UDC_PRESCALE_EN is defined.
module udc_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] phase;

    // A clear cycle never ticks; it only restarts the phase.
    assign tick = enable && !clear && (phase == LAST);

    // Phase counter: cleared by reset or clear, advances on enabled cycles.
    always_ff @(posedge clock) begin
        if (!reset) begin
            phase <= '0;
        end else if (clear) begin
            phase <= '0;
        end else if (enable) begin
            phase <= tick ? '0 : phase + CW'(1);
        end
    end

endmodule

// File: rtl/param_up_down_counter.sv
// Parameterised up/down counter with runtime limit, wrap/saturate mode,
// parallel load, bound flags and registered overflow/underflow pulses.
// Optional step prescaler compiled in with the UDC_PRESCALE_EN macro.
module param_up_down_counter
    import param_udc_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               PRESCALE    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] limit,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             ovf,
    output logic             udf
);

    logic             step;
    logic [WIDTH-1:0] count_next;
    logic             ovf_next;
    logic             udf_next;
    udc_mode_t        step_mode;

`ifdef UDC_PRESCALE_EN
    logic tick;

    udc_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .clear  (load),
        .tick   (tick)
    );

    assign step = enable && !load && tick;
`else
    assign step = enable && !load;
`endif

    assign step_mode = udc_mode_t'(mode);
    assign at_max    = (count >= limit);
    assign at_zero   = (count == '0);

    // Next-count selection: load beats step; bounds are checked before any
    // arithmetic so the natural 2^WIDTH rollover can never happen.
    always_comb begin
        count_next = count;
        ovf_next   = 1'b0;
        udf_next   = 1'b0;
        if (load) begin
            count_next = (load_value > limit) ? limit : load_value;
        end else if (step) begin
            if (up_down == UDC_UP) begin
                if (count < limit) begin
                    count_next = count + WIDTH'(1);
                end else begin
                    count_next = (step_mode == UDC_SAT) ? limit : '0;
                    ovf_next   = 1'b1;
                end
            end else if (up_down == UDC_DOWN) begin
                if (count != '0) begin
                    count_next = count - WIDTH'(1);
                end else begin
                    count_next = (step_mode == UDC_SAT) ? '0 : limit;
                    udf_next   = 1'b1;
                end
            end
        end
    end

    // Single register stage for count and the event pulses.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= RESET_VALUE;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            count <= count_next;
            ovf   <= ovf_next;
            udf   <= udf_next;
        end
    end

endmodule
